// File: rtl/mem_interface_unit_pkg.sv
// mem_interface_unit_pkg: shared FSM, data-type encodings and extension helper
package mem_interface_unit_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, ACCESS = 2'b01, DONE = 2'b10} state_t;
  localparam logic [1:0] DT_BYTE = 2'b00;
  localparam logic [1:0] DT_HALF = 2'b01;
  localparam logic [1:0] DT_WORD = 2'b10;
  localparam logic [1:0] DT_RSVD = 2'b11;
  localparam int WAIT_STATES_DEF = 2;
  function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] dt, input logic sgn);
    return dt == DT_BYTE ? {{24{sgn & d[7]}}, d[7:0]} :
           dt == DT_HALF ? {{16{sgn & d[15]}}, d[15:0]} : d;
  endfunction
endpackage

// File: rtl/mem_interface_unit_if.sv
// mem_interface_unit_if: datapath-to-memory-unit request/response bundle
interface mem_interface_unit_if;
  logic        MAR_LD;
  logic        MDR_LD;
  logic        MOV;
  logic        RW;
  logic [1:0]  DT;
  logic        SIGNED_LD;
  logic [31:0] ALU_OUT;
  logic        MOC;
  logic [31:0] MAR_Q;
  logic [31:0] MDR_Q;
  modport master (output MAR_LD, MDR_LD, MOV, RW, DT, SIGNED_LD, ALU_OUT, input MOC, MAR_Q, MDR_Q);
  modport slave (input MAR_LD, MDR_LD, MOV, RW, DT, SIGNED_LD, ALU_OUT, output MOC, MAR_Q, MDR_Q);
endinterface

// File: rtl/mem_interface_unit_ram.sv
// mem_ram: byte-wide RAM, 4-lane byte-enabled write, combinational 4-byte read
module mem_ram #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [3:0]        be_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);
  logic [7:0] mem_q [2**ADDR_W];
  // lane i writes the byte at addr_i+i (little-endian), no reset of contents
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (we_i && be_i[i]) mem_q[addr_i + ADDR_W'(i)] <= wdata_i[8*i +: 8];
  assign rdata_o = {mem_q[addr_i + ADDR_W'(3)], mem_q[addr_i + ADDR_W'(2)],
                    mem_q[addr_i + ADDR_W'(1)], mem_q[addr_i]};
endmodule

// File: rtl/mem_interface_unit.sv
// mem_interface_unit: MAR/MDR memory unit with wait-state FSM and MOV/MOC four-phase handshake
module mem_interface_unit
  import mem_interface_unit_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int WAIT_STATES = WAIT_STATES_DEF
) (
  input logic CLK,
  input logic RST_N,
  mem_interface_unit_if.slave bus
);
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       mar_q, mar_d, mdr_q, mdr_d, rdata;
  logic              rw_q, rw_d, sgn_q, sgn_d, moc_q, idle, fire;
  logic [1:0]        dt_q, dt_d;
  logic [3:0]        be;
  logic [ADDR_W-1:0] ea;
  assign idle = state_q == IDLE;
  assign fire = state_q == ACCESS && cnt_q == WS;
  assign ea = mar_q[ADDR_W-1:0] & ~ADDR_W'(dt_q == DT_HALF ? 1 : (dt_q == DT_WORD || dt_q == DT_RSVD) ? 3 : 0);
  assign be = dt_q == DT_BYTE ? 4'b0001 : dt_q == DT_HALF ? 4'b0011 : 4'b1111;
  mem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk(CLK), .we_i(fire && !rw_q), .be_i(be), .addr_i(ea), .wdata_i(mdr_q), .rdata_o(rdata)
  );
  // next state: register loads only in IDLE, read data captured on the completing edge
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    dt_d    = dt_q;
    sgn_d   = sgn_q;
    mar_d   = idle && bus.MAR_LD ? bus.ALU_OUT : mar_q;
    mdr_d   = idle && bus.MDR_LD ? bus.ALU_OUT : fire && rw_q ? extend(rdata, dt_q, sgn_q) : mdr_q;
    case (state_q)
      IDLE: if (bus.MOV) begin
        state_d = ACCESS;
        cnt_d   = '0;
        rw_d    = bus.RW;
        dt_d    = bus.DT;
        sgn_d   = bus.SIGNED_LD;
      end
      ACCESS: begin
        cnt_d   = cnt_q + 4'd1;
        state_d = fire ? DONE : ACCESS;
      end
      DONE:    state_d = bus.MOV ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state registers; MOC registered from the next state so it is high exactly in DONE
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mar_q   <= '0;
      mdr_q   <= '0;
      rw_q    <= 1'b0;
      dt_q    <= '0;
      sgn_q   <= 1'b0;
      moc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      rw_q    <= rw_d;
      dt_q    <= dt_d;
      sgn_q   <= sgn_d;
      moc_q   <= state_d == DONE;
    end
  assign bus.MOC   = moc_q;
  assign bus.MAR_Q = mar_q;
  assign bus.MDR_Q = mdr_q;
endmodule

// File: tb/tb_mem_interface_unit.sv
// tb_mem_interface_unit: directed stimulus with scoreboard-checked MDR and MOC latency
module tb_mem_interface_unit;
  localparam int WS = 2;
  typedef struct {
    logic [31:0] mdr;
    int          lat;
  } exp_t;
  logic CLK = 1'b0;
  logic RST_N = 1'b1;
  int tests = 0, fails = 0, cyc = 0, t_mov = 0;
  logic mov_p = 1'b0, moc_p = 1'b0;
  exp_t sb[$];
  exp_t e;
  mem_interface_unit_if bus ();
  mem_interface_unit #(.ADDR_W(9), .WAIT_STATES(WS)) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));
  always #5 CLK = ~CLK;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge CLK) begin
    cyc++;
    if (bus.MOV && !mov_p) t_mov = cyc;
    if (bus.MOC && !moc_p) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_moc: got MOC rise with empty scoreboard at %0t", $time);
      end else begin
        e = sb.pop_front();
        check("mdr", bus.MDR_Q, e.mdr);
        check("moc_latency", 32'(cyc - t_mov), 32'(e.lat));
      end
    end
    mov_p = bus.MOV;
    moc_p = bus.MOC;
  end
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic load(input logic [31:0] addr, input logic [31:0] data);
    bus.MAR_LD = 1'b1;
    bus.ALU_OUT = addr;
    tick();
    bus.MAR_LD = 1'b0;
    bus.MDR_LD = 1'b1;
    bus.ALU_OUT = data;
    tick();
    bus.MDR_LD = 1'b0;
  endtask
  task automatic start(input logic rw, input logic [1:0] dt, input logic sgn, input logic [31:0] exp);
    bus.RW = rw;
    bus.DT = dt;
    bus.SIGNED_LD = sgn;
    bus.MOV = 1'b1;
    sb.push_back('{exp, WS + 2});
  endtask
  task automatic finish(input int hold);
    for (int i = 0; i < 40 && bus.MOC !== 1'b1; i++) tick();
    check("moc_seen", {31'b0, bus.MOC}, 32'd1);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("moc_hold", {31'b0, bus.MOC}, 32'd1);
    end
    bus.MOV = 1'b0;
    tick();
    check("moc_release", {31'b0, bus.MOC}, 32'd0);
  endtask
  task automatic op(input logic [31:0] addr, input logic [31:0] data, input logic rw,
                    input logic [1:0] dt, input logic sgn, input logic [31:0] exp);
    load(addr, data);
    start(rw, dt, sgn, exp);
    finish(0);
  endtask
  initial begin
    bus.MAR_LD = 0; bus.MDR_LD = 0; bus.MOV = 0; bus.RW = 0;
    bus.DT = 2'b00; bus.SIGNED_LD = 0; bus.ALU_OUT = '0;
    #1 RST_N = 1'b0;
    #11;
    check("rst_moc", {31'b0, bus.MOC}, 32'd0);
    check("rst_mar", bus.MAR_Q, 32'd0);
    check("rst_mdr", bus.MDR_Q, 32'd0);
    tick();
    RST_N = 1'b1;
    tick();
    op(32'h10, 32'hDEADBEEF, 1'b0, 2'b10, 1'b0, 32'hDEADBEEF);
    op(32'h10, 32'h0, 1'b1, 2'b10, 1'b0, 32'hDEADBEEF);
    op(32'h13, 32'h0, 1'b1, 2'b00, 1'b0, 32'h000000DE);
    op(32'h13, 32'h0, 1'b1, 2'b00, 1'b1, 32'hFFFFFFDE);
    op(32'h11, 32'h0, 1'b1, 2'b01, 1'b0, 32'h0000BEEF);
    op(32'h10, 32'h0, 1'b1, 2'b01, 1'b1, 32'hFFFFBEEF);
    op(32'h10, 32'h0, 1'b1, 2'b00, 1'b1, 32'hFFFFFFEF);
    op(32'h13, 32'h0, 1'b1, 2'b11, 1'b0, 32'hDEADBEEF);
    op(32'h12, 32'h55, 1'b0, 2'b00, 1'b0, 32'h00000055);
    op(32'h10, 32'h0, 1'b1, 2'b10, 1'b0, 32'hDE55BEEF);
    op(32'hFFFF_FE10, 32'h0, 1'b1, 2'b10, 1'b0, 32'hDE55BEEF);
    load(32'h14, 32'h11223344);
    start(1'b0, 2'b10, 1'b0, 32'h11223344);
    finish(5);
    op(32'h14, 32'h0, 1'b1, 2'b10, 1'b0, 32'h11223344);
    load(32'h18, 32'hCAFEF00D);
    start(1'b0, 2'b10, 1'b0, 32'hCAFEF00D);
    tick();
    bus.MOV = 1'b0;
    finish(0);
    op(32'h18, 32'h0, 1'b1, 2'b10, 1'b0, 32'hCAFEF00D);
    load(32'h1C, 32'h0BADF00D);
    start(1'b0, 2'b10, 1'b0, 32'h0BADF00D);
    tick();
    bus.MAR_LD = 1'b1;
    bus.MDR_LD = 1'b1;
    bus.ALU_OUT = 32'h20;
    tick();
    bus.MAR_LD = 1'b0;
    bus.MDR_LD = 1'b0;
    check("mar_ld_ignored", bus.MAR_Q, 32'h1C);
    check("mdr_ld_ignored", bus.MDR_Q, 32'h0BADF00D);
    finish(0);
    op(32'h1C, 32'h0, 1'b1, 2'b10, 1'b0, 32'h0BADF00D);
    op(32'h30, 32'h12345678, 1'b0, 2'b10, 1'b0, 32'h12345678);
    load(32'h30, 32'hFFFFFFFF);
    bus.RW = 1'b0;
    bus.DT = 2'b10;
    bus.MOV = 1'b1;
    tick();
    tick();
    RST_N = 1'b0;
    #1;
    check("abort_moc", {31'b0, bus.MOC}, 32'd0);
    check("abort_mar", bus.MAR_Q, 32'd0);
    check("abort_mdr", bus.MDR_Q, 32'd0);
    bus.MOV = 1'b0;
    tick();
    RST_N = 1'b1;
    tick();
    op(32'h30, 32'h0, 1'b1, 2'b10, 1'b0, 32'h12345678);
    tick();
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
